ram_fifo_ctrl: RTL and testbench

- Controller that turns an external 1-read/1-write register array into a first-word-fall-through FIFO with valid/ready handshakes on both sides.
- It is the client end of the array interface: it drives the write select, write data, write enable and read select, and consumes the combinational read data.
- Used in the OoO core for instruction/issue queues. Storage stays outside the block, so the same array module is reused unchanged.

---
 rtl/ram_fifo_ctrl_pkg.sv | 25 ++
 rtl/ram_fifo_ctrl_wrap_ptr.sv | 47 ++++
 rtl/ram_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared types for the RAM-backed FIFO controller.
// upd_e names the single state update applied in a cycle; upd_kind() decodes it
// from the gated handshake terms so pointer and count logic agree on priority.
package ram_fifo_ctrl_pkg;

  typedef enum logic [2:0] {
    UpdHold,
    UpdPush,
    UpdPop,
    UpdBoth,
    UpdFlush
  } upd_e;

  // Priority: gwe low holds everything, then flush beats any handshake.
  function automatic upd_e upd_kind(input logic gwe, input logic flush,
                                    input logic push, input logic pop);
    if (!gwe) return UpdHold;
    if (flush) return UpdFlush;
    if (push && pop) return UpdBoth;
    if (push) return UpdPush;
    if (pop) return UpdPop;
    return UpdHold;
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_wrap_ptr.sv
// Wrapping pointer register for the FIFO controller.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset (pointer -> 0)
//   gwe  - global write enable; pointer holds when low
//   clr  - synchronous clear (qualified by gwe), overrides inc
//   inc  - advance pointer by one, wrapping modulo 2**addr_width
//   ptr  - current pointer value
module ram_fifo_ctrl_wrap_ptr #(
  parameter int unsigned addr_width = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gwe,
  input  logic                  clr,
  input  logic                  inc,
  output logic [addr_width-1:0] ptr
);

  localparam logic [addr_width-1:0] ptr_one = addr_width'(1);

  logic [addr_width-1:0] ptr_q;
  logic [addr_width-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (gwe) begin
      if (clr) begin
        ptr_d = '0;
      end else if (inc) begin
        // Natural overflow gives the modulo-depth wrap.
        ptr_d = ptr_q + ptr_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external 1R/1W register array.
// Storage lives outside; this block owns the pointers and occupancy count.
// Ports:
//   clk, rst             - clock (rising edge), async active-low reset
//   gwe                  - global write enable; no state change when low
//   flush                - synchronous clear of queue state (gwe-qualified)
//   in_valid/in_data     - producer side; in_ready = queue not full
//   out_valid/out_data   - consumer side head entry; out_ready takes it
//   count                - stored entries, 0..depth
//   ram_wsel/wdata/we    - array write port
//   ram_rsel/ram_rdata   - array read port (combinational read data)
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned bit_width  = 16,
  parameter int unsigned addr_width = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gwe,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [bit_width-1:0]  in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [bit_width-1:0]  out_data,
  input  logic                  out_ready,
  output logic [addr_width:0]   count,
  output logic [addr_width-1:0] ram_wsel,
  output logic [bit_width-1:0]  ram_wdata,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_rsel,
  input  logic [bit_width-1:0]  ram_rdata
);

  localparam logic [addr_width:0] depth   = (addr_width + 1)'(1) << addr_width;
  localparam logic [addr_width:0] cnt_one = (addr_width + 1)'(1);

  logic [addr_width:0]   count_q;
  logic [addr_width:0]   count_d;
  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  upd_e                  upd;

  // Handshake status decodes only registered state: no input-to-output path.
  assign full      = (count_q == depth);
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = gwe & !flush & in_valid & in_ready;
  assign pop  = gwe & !flush & out_valid & out_ready;

  assign ram_wsel  = wr_ptr;
  assign ram_wdata = in_data;
  assign ram_we    = push;
  assign ram_rsel  = rd_ptr;
  assign out_data  = ram_rdata;

  assign upd = upd_kind(gwe, flush, push, pop);

  always_comb begin
    count_d = count_q;
    unique case (upd)
      UpdFlush: count_d = '0;
      UpdPush:  count_d = count_q + cnt_one;
      UpdPop:   count_d = count_q - cnt_one;
      default:  count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

  ram_fifo_ctrl_wrap_ptr #(
    .addr_width(addr_width)
  ) u_wr_ptr (
    .clk(clk),
    .rst(rst),
    .gwe(gwe),
    .clr(flush),
    .inc(push),
    .ptr(wr_ptr)
  );

  ram_fifo_ctrl_wrap_ptr #(
    .addr_width(addr_width)
  ) u_rd_ptr (
    .clk(clk),
    .rst(rst),
    .gwe(gwe),
    .clr(flush),
    .inc(pop),
    .ptr(rd_ptr)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl (depth 4, 16-bit entries) with a behavioural 1R/1W array.
module tb_ram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        gwe;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [2:0]  count;
  logic [1:0]  ram_wsel;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [1:0]  ram_rsel;
  logic [15:0] ram_rdata;

  logic [15:0] mem [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_wsel] <= ram_wdata;
  assign ram_rdata = mem[ram_rsel];

  ram_fifo_ctrl #(
    .bit_width(16),
    .addr_width(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gwe(gwe),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .count(count),
    .ram_wsel(ram_wsel),
    .ram_wdata(ram_wdata),
    .ram_we(ram_we),
    .ram_rsel(ram_rsel),
    .ram_rdata(ram_rdata)
  );

  typedef struct {
    logic        gwe;
    logic        flush;
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic [2:0]  e_cnt;
    logic        e_ir;
    logic        e_ov;
    logic        e_we;
    logic [1:0]  e_wsel;
    logic [1:0]  e_rsel;
    logic [15:0] e_od;
    logic        chk_od;
  } vec_t;

  localparam int NumVec = 26;
  vec_t vec [NumVec];

  function automatic vec_t mk(logic g, logic f, logic iv, logic [15:0] id, logic ordy,
                              logic [2:0] cnt, logic ir, logic ov, logic we,
                              logic [1:0] wsel, logic [1:0] rsel, logic [15:0] od,
                              logic chk_od);
    vec_t v;
    v.gwe = g; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_cnt = cnt; v.e_ir = ir; v.e_ov = ov; v.e_we = we;
    v.e_wsel = wsel; v.e_rsel = rsel; v.e_od = od; v.chk_od = chk_od;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // Columns: gwe flush in_valid in_data out_ready | count in_ready out_valid we wsel rsel
    //          out_data check_out_data. Expected values are pre-edge for that cycle.
    // Fill.
    vec[0]  = mk(1, 0, 1, 16'h1111, 0, 3'd0, 1, 0, 1, 2'd0, 2'd0, 16'h0000, 0);
    vec[1]  = mk(1, 0, 1, 16'h2222, 0, 3'd1, 1, 1, 1, 2'd1, 2'd0, 16'h1111, 1);
    vec[2]  = mk(1, 0, 1, 16'h3333, 0, 3'd2, 1, 1, 1, 2'd2, 2'd0, 16'h1111, 1);
    vec[3]  = mk(1, 0, 1, 16'h4444, 0, 3'd3, 1, 1, 1, 2'd3, 2'd0, 16'h1111, 1);
    // Full: in_valid is back-pressured.
    vec[4]  = mk(1, 0, 1, 16'h9999, 0, 3'd4, 0, 1, 0, 2'd0, 2'd0, 16'h1111, 1);
    // Drain.
    vec[5]  = mk(1, 0, 0, 16'h0000, 1, 3'd4, 0, 1, 0, 2'd0, 2'd0, 16'h1111, 1);
    vec[6]  = mk(1, 0, 0, 16'h0000, 1, 3'd3, 1, 1, 0, 2'd0, 2'd1, 16'h2222, 1);
    vec[7]  = mk(1, 0, 0, 16'h0000, 1, 3'd2, 1, 1, 0, 2'd0, 2'd2, 16'h3333, 1);
    vec[8]  = mk(1, 0, 0, 16'h0000, 1, 3'd1, 1, 1, 0, 2'd0, 2'd3, 16'h4444, 1);
    // Empty: out_ready has no effect, rd_ptr wrapped.
    vec[9]  = mk(1, 0, 0, 16'h0000, 1, 3'd0, 1, 0, 0, 2'd0, 2'd0, 16'h0000, 0);
    // Build count=2, wr_ptr=3.
    vec[10] = mk(1, 0, 1, 16'h0A0A, 0, 3'd0, 1, 0, 1, 2'd0, 2'd0, 16'h0000, 0);
    vec[11] = mk(1, 0, 1, 16'h0B0B, 0, 3'd1, 1, 1, 1, 2'd1, 2'd0, 16'h0A0A, 1);
    vec[12] = mk(1, 0, 1, 16'h0C0C, 0, 3'd2, 1, 1, 1, 2'd2, 2'd0, 16'h0A0A, 1);
    vec[13] = mk(1, 0, 0, 16'h0000, 1, 3'd3, 1, 1, 0, 2'd3, 2'd0, 16'h0A0A, 1);
    // Simultaneous push/pop with wr_ptr wrap 3 -> 0.
    vec[14] = mk(1, 0, 1, 16'hAAAA, 1, 3'd2, 1, 1, 1, 2'd3, 2'd1, 16'h0B0B, 1);
    vec[15] = mk(1, 0, 0, 16'h0000, 0, 3'd2, 1, 1, 0, 2'd0, 2'd2, 16'h0C0C, 1);
    // Refill to full, then push+pop attempt while full.
    vec[16] = mk(1, 0, 1, 16'h1234, 0, 3'd2, 1, 1, 1, 2'd0, 2'd2, 16'h0C0C, 1);
    vec[17] = mk(1, 0, 1, 16'h5678, 0, 3'd3, 1, 1, 1, 2'd1, 2'd2, 16'h0C0C, 1);
    vec[18] = mk(1, 0, 1, 16'hDEAD, 1, 3'd4, 0, 1, 0, 2'd2, 2'd2, 16'h0C0C, 1);
    vec[19] = mk(1, 0, 0, 16'h0000, 0, 3'd3, 1, 1, 0, 2'd2, 2'd3, 16'hAAAA, 1);
    // gwe gating: three cycles of would-be push+pop.
    vec[20] = mk(0, 0, 1, 16'hBEEF, 1, 3'd3, 1, 1, 0, 2'd2, 2'd3, 16'hAAAA, 1);
    vec[21] = mk(0, 0, 1, 16'hBEEF, 1, 3'd3, 1, 1, 0, 2'd2, 2'd3, 16'hAAAA, 1);
    vec[22] = mk(0, 0, 1, 16'hBEEF, 1, 3'd3, 1, 1, 0, 2'd2, 2'd3, 16'hAAAA, 1);
    vec[23] = mk(1, 0, 0, 16'h0000, 0, 3'd3, 1, 1, 0, 2'd2, 2'd3, 16'hAAAA, 1);
    // Flush while pushing: no write, everything clears.
    vec[24] = mk(1, 1, 1, 16'h5555, 0, 3'd3, 1, 1, 0, 2'd2, 2'd3, 16'hAAAA, 1);
    vec[25] = mk(1, 0, 0, 16'h0000, 0, 3'd0, 1, 0, 0, 2'd0, 2'd0, 16'h0000, 0);

    rst = 1'b0; gwe = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    check("reset_count", 32'(count), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_ram_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      gwe = vec[i].gwe; flush = vec[i].flush; in_valid = vec[i].iv;
      in_data = vec[i].id; out_ready = vec[i].ordy;
      #1;
      check($sformatf("v%0d_count", i), 32'(count), 32'(vec[i].e_cnt));
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vec[i].e_ir));
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vec[i].e_ov));
      check($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vec[i].e_we));
      check($sformatf("v%0d_ram_wsel", i), 32'(ram_wsel), 32'(vec[i].e_wsel));
      check($sformatf("v%0d_ram_rsel", i), 32'(ram_rsel), 32'(vec[i].e_rsel));
      if (vec[i].e_we) check($sformatf("v%0d_ram_wdata", i), 32'(ram_wdata), 32'(vec[i].id));
      if (vec[i].chk_od) check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vec[i].e_od));
      @(negedge clk);
    end

    // Push one entry, then drop reset mid-cycle.
    gwe = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'h7777; out_ready = 1'b0;
    #1;
    check("pre_rst_push_we", 32'(ram_we), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    check("pre_rst_count", 32'(count), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_data = 16'h8888;
    #1;
    check("post_rst_wsel", 32'(ram_wsel), 32'd0);
    check("post_rst_we", 32'(ram_we), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("post_rst_out_data", 32'(out_data), 32'h8888);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_rsel", 32'(ram_rsel), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
